// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback, waits on mem_ready in the
// memory states and parks in a sticky HALT on illegal opcodes or memory timeouts.
// Handshake: the memory side completes an access in any cycle where the FSM is
// in a memory state (FETCH/MEM_READ/MEM_WRITE) and mem_ready is high; the FSM
// holds its strobes and state until then, or until the wait limit is reached.
module multicycle_control_fsm #(
   parameter int MEM_HANDSHAKE  = 1,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] ALUOp,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic [3:0] state_o,
   output logic       illegal_op,
   output logic       bus_error
);

   typedef enum logic [3:0] {
      S_RST       = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_EXEC_R    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_EXEC_I    = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11,
      S_HALT      = 4'd15
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BNE  = 6'b000101;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LUI  = 6'b001111;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;

   // Last permissible wait count: the cycle that would make the count reach the limit.
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t     state_q, state_d;
   logic [5:0] op_q, op_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       illegal_q, illegal_d;
   logic       bus_error_q, bus_error_d;

   logic ready_eff;
   logic mem_state;
   logic timeout;

   // With the handshake disabled every memory access completes immediately.
   assign ready_eff = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);
   // mem_ready in the limit cycle still completes the access normally.
   assign timeout   = (MEM_HANDSHAKE != 0) && mem_state && !mem_ready && (wait_cnt_q == TO_LAST);

   assign state_o    = state_q;
   assign illegal_op = illegal_q;
   assign bus_error  = bus_error_q;

   // State, latched opcode, wait counter and sticky error flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_RST;
         op_q        <= 6'd0;
         wait_cnt_q  <= 8'd0;
         illegal_q   <= 1'b0;
         bus_error_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         wait_cnt_q  <= wait_cnt_d;
         illegal_q   <= illegal_d;
         bus_error_q <= bus_error_d;
      end
   end

   // Next-state and control decode; every control defaults to 0.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      wait_cnt_d  = wait_cnt_q;
      illegal_d   = illegal_q;
      bus_error_d = bus_error_q;
      ALUOp       = 3'b000;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSrc       = 2'b00;
      PCWrite     = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegDst      = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;

      case (state_q)
         S_RST: state_d = S_FETCH;
         S_FETCH: begin
            ALUSrcB = 2'b01;
            if (timeout) begin
               bus_error_d = 1'b1;
               state_d     = S_HALT;
            end else begin
               MemRead = 1'b1;
               IRWrite = ready_eff;
               PCWrite = ready_eff;
               if (ready_eff) state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            // ALU precomputes the branch target into ALUOut while decoding.
            ALUSrcB = 2'b11;
            op_d    = opcode;
            case (opcode)
               OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
               OP_R:                            state_d = S_EXEC_R;
               OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
               OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
               OP_J:                            state_d = S_JUMP;
               default: begin
                  illegal_d = 1'b1;
                  state_d   = S_HALT;
               end
            endcase
         end
         S_MEM_ADDR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (op_q == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            IorD = 1'b1;
            if (timeout) begin
               bus_error_d = 1'b1;
               state_d     = S_HALT;
            end else begin
               MemRead = 1'b1;
               if (ready_eff) state_d = S_MEM_WB;
            end
         end
         S_MEM_WB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_MEM_WRITE: begin
            IorD = 1'b1;
            if (timeout) begin
               bus_error_d = 1'b1;
               state_d     = S_HALT;
            end else begin
               MemWrite = 1'b1;
               if (ready_eff) state_d = S_FETCH;
            end
         end
         S_EXEC_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b111;
            state_d = S_ALU_WB;
         end
         S_ALU_WB: begin
            RegDst   = (op_q == OP_R);
            RegWrite = 1'b1;
            state_d  = S_FETCH;
         end
         S_EXEC_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (op_q)
               OP_ORI:  ALUOp = 3'b101;
               OP_ANDI: ALUOp = 3'b110;
               OP_LUI:  ALUOp = 3'b011;
               default: ALUOp = 3'b100;
            endcase
            state_d = S_ALU_WB;
         end
         S_BRANCH: begin
            // op_q[0] distinguishes bne (taken on !zero) from beq (taken on zero).
            ALUSrcA = 1'b1;
            ALUOp   = 3'b001;
            PCSrc   = 2'b01;
            PCWrite = zero ^ op_q[0];
            state_d = S_FETCH;
         end
         S_JUMP: begin
            PCSrc   = 2'b10;
            PCWrite = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_HALT;
      endcase

      // Any state change restarts the wait count; it only advances while stalled.
      if (state_d != state_q) begin
         wait_cnt_d = 8'd0;
      end else if (mem_state && !ready_eff) begin
         wait_cnt_d = wait_cnt_q + 8'd1;
      end
   end

endmodule
